// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_skid
//  Description : IF->ID pipeline register with valid/ready handshake, a
//                two-entry skid buffer and flush-to-bubble.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_skid #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [1:0]        occ
);

    localparam logic [1:0] C_EMPTY = 2'd0;
    localparam logic [1:0] C_ONE   = 2'd1;
    localparam logic [1:0] C_TWO   = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] main_pc_q,   main_pc_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [ADDR_W-1:0] skid_pc_q,   skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;

    logic w_in_fire;
    logic w_out_fire;

    // State and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= C_EMPTY;
            main_pc_q   <= '0;
            main_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    assign w_in_fire  = if_valid & if_ready;
    assign w_out_fire = id_valid & id_ready;

    // Next state; main is forced to the bubble whenever the stage empties so
    // id_pc/id_inst can come straight from the flops.
    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (flush) begin
            state_d     = C_EMPTY;
            main_pc_d   = '0;
            main_inst_d = NOP_INST;
            skid_pc_d   = '0;
            skid_inst_d = NOP_INST;
        end else begin
            case (state_q)
                C_EMPTY: begin
                    if (w_in_fire) begin
                        state_d     = C_ONE;
                        main_pc_d   = if_pc;
                        main_inst_d = if_inst;
                    end
                end
                C_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        main_pc_d   = if_pc;
                        main_inst_d = if_inst;
                    end else if (w_in_fire) begin
                        state_d     = C_TWO;
                        skid_pc_d   = if_pc;
                        skid_inst_d = if_inst;
                    end else if (w_out_fire) begin
                        state_d     = C_EMPTY;
                        main_pc_d   = '0;
                        main_inst_d = NOP_INST;
                    end
                end
                C_TWO: begin
                    if (w_out_fire) begin
                        state_d     = C_ONE;
                        main_pc_d   = skid_pc_q;
                        main_inst_d = skid_inst_q;
                        skid_pc_d   = '0;
                        skid_inst_d = NOP_INST;
                    end
                end
                default: begin
                    state_d     = C_EMPTY;
                    main_pc_d   = '0;
                    main_inst_d = NOP_INST;
                    skid_pc_d   = '0;
                    skid_inst_d = NOP_INST;
                end
            endcase
        end
    end

    // Outputs depend only on registered state and rst
    always_comb begin
        if_ready = (state_q != C_TWO) & ~rst;
        id_valid = (state_q != C_EMPTY);
        id_pc    = main_pc_q;
        id_inst  = main_inst_q;
        occ      = state_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_skid
//  Description : Directed vector table plus a handshake scoreboard run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_skid;

    localparam int C_AW = 32;
    localparam int C_IW = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            if_valid;
    logic            if_ready;
    logic [C_AW-1:0] if_pc;
    logic [C_IW-1:0] if_inst;
    logic            id_valid;
    logic            id_ready;
    logic [C_AW-1:0] id_pc;
    logic [C_IW-1:0] id_inst;
    logic [1:0]      occ;

    int n_cmp;
    int n_err;

    if_id_skid #(
        .ADDR_W   (C_AW),
        .INST_W   (C_IW),
        .NOP_INST ({C_IW{1'b0}})
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .occ      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            flush;
        logic            iv;
        logic [C_AW-1:0] pc;
        logic            idr;
        logic            e_rdy;
        logic            e_val;
        logic [C_AW-1:0] e_pc;
        logic [1:0]      e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [C_IW-1:0] inst_of(input logic [C_AW-1:0] pc);
        return 32'hC000_0000 | pc;
    endfunction

    task automatic add(input logic r, input logic f, input logic iv,
                       input logic [C_AW-1:0] pc, input logic idr,
                       input logic e_rdy, input logic e_val,
                       input logic [C_AW-1:0] e_pc, input logic [1:0] e_occ);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.idr = idr;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_pc = e_pc; v.e_occ = e_occ;
        vecs.push_back(v);
    endtask

    initial begin
        logic [C_AW-1:0] exp_q[$];
        logic [C_AW-1:0] next_pc;
        logic [15:0]     rdy_pat;
        logic            in_f;
        logic            out_f;
        logic [C_IW-1:0] e_inst;
        int              budget;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;

        //   rst flush iv  pc        idr | rdy val pc        occ
        add(1, 0, 0, 32'h00, 0,   0, 0, 32'h00, 2'd0);   // reset
        add(1, 0, 0, 32'h00, 0,   0, 0, 32'h00, 2'd0);
        add(0, 0, 0, 32'h00, 1,   1, 0, 32'h00, 2'd0);   // release
        add(0, 0, 1, 32'h00, 1,   1, 1, 32'h00, 2'd1);   // streaming
        add(0, 0, 1, 32'h04, 1,   1, 1, 32'h04, 2'd1);
        add(0, 0, 1, 32'h08, 1,   1, 1, 32'h08, 2'd1);
        add(0, 0, 0, 32'h00, 1,   1, 0, 32'h00, 2'd0);
        add(0, 0, 1, 32'h10, 0,   1, 1, 32'h10, 2'd1);   // back-pressure into skid
        add(0, 0, 1, 32'h14, 0,   0, 1, 32'h10, 2'd2);
        add(0, 0, 1, 32'h18, 0,   0, 1, 32'h10, 2'd2);   // not accepted, data stable
        add(0, 0, 0, 32'h00, 1,   1, 1, 32'h14, 2'd1);
        add(0, 0, 0, 32'h00, 1,   1, 0, 32'h00, 2'd0);
        add(0, 0, 1, 32'h20, 0,   1, 1, 32'h20, 2'd1);   // flush from TWO
        add(0, 0, 1, 32'h24, 0,   0, 1, 32'h20, 2'd2);
        add(0, 1, 1, 32'h28, 0,   1, 0, 32'h00, 2'd0);
        add(0, 0, 0, 32'h00, 1,   1, 0, 32'h00, 2'd0);
        add(0, 1, 1, 32'h30, 1,   1, 0, 32'h00, 2'd0);   // flush with in_fire from EMPTY
        add(0, 0, 1, 32'h40, 1,   1, 1, 32'h40, 2'd1);
        add(0, 0, 0, 32'h00, 1,   1, 0, 32'h00, 2'd0);
        add(0, 0, 1, 32'h50, 0,   1, 1, 32'h50, 2'd1);   // reset while full
        add(0, 0, 1, 32'h54, 0,   0, 1, 32'h50, 2'd2);
        add(1, 0, 1, 32'h58, 0,   0, 0, 32'h00, 2'd0);
        add(0, 0, 0, 32'h00, 1,   1, 0, 32'h00, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            flush    = vecs[i].flush;
            if_valid = vecs[i].iv;
            if_pc    = vecs[i].pc;
            if_inst  = inst_of(vecs[i].pc);
            id_ready = vecs[i].idr;
            @(posedge clk);
            #1;
            e_inst = vecs[i].e_val ? inst_of(vecs[i].e_pc) : '0;
            n_cmp++;
            if (if_ready !== vecs[i].e_rdy || id_valid !== vecs[i].e_val ||
                id_pc !== vecs[i].e_pc || id_inst !== e_inst || occ !== vecs[i].e_occ) begin
                n_err++;
                $display("FAIL vec%0d: got rdy=%b val=%b pc=%h inst=%h occ=%0d, want rdy=%b val=%b pc=%h inst=%h occ=%0d",
                         i, if_ready, id_valid, id_pc, id_inst, occ,
                         vecs[i].e_rdy, vecs[i].e_val, vecs[i].e_pc, e_inst, vecs[i].e_occ);
            end
        end

        // Scoreboard run: irregular valid/ready, order and occupancy must track a FIFO model
        next_pc = 32'h100;
        rdy_pat = 16'b0011_0110_1001_1100;
        budget  = 0;
        for (int c = 0; c < 60; c++) begin
            flush    = 1'b0;
            rst      = 1'b0;
            if_valid = (c < 40) && ((c % 4) != 3);
            if_pc    = next_pc;
            if_inst  = inst_of(next_pc);
            id_ready = (c < 40) ? rdy_pat[c % 16] : 1'b1;
            #4;
            in_f  = if_valid & if_ready;
            out_f = id_valid & id_ready;
            if (out_f) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_spurious: got pc=%h, want no output", id_pc);
                end else if (id_pc !== exp_q[0] || id_inst !== inst_of(exp_q[0])) begin
                    n_err++;
                    $display("FAIL sb_order: got pc=%h inst=%h, want pc=%h inst=%h",
                             id_pc, id_inst, exp_q[0], inst_of(exp_q[0]));
                end
            end
            @(posedge clk);
            #1;
            if (out_f && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_f) begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'h4;
            end
            n_cmp++;
            if (occ !== 2'(exp_q.size())) begin
                n_err++;
                $display("FAIL sb_occ cycle%0d: got %0d, want %0d", c, occ, exp_q.size());
            end
            budget++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || next_pc == 32'h100) begin
            n_err++;
            $display("FAIL sb_drain: got %0d left / next_pc=%h, want 0 left and traffic", exp_q.size(), next_pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
